// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
// Shared sizing constants and types for the three-port register file.
//
// Contents:
//   REG_WIDTH / REG_DEPTH / REG_ADDR_W : default data width, register count
//                                        and address width
//   reg_data_t / reg_addr_t            : data and address types at the
//                                        default sizes
//   ZERO_REG                           : address of the hardwired-zero
//                                        register
// ---------------------------------------------------------------------------
package regfile_pkg;

    localparam int REG_WIDTH  = 32;
    localparam int REG_DEPTH  = 32;
    localparam int REG_ADDR_W = 5;

    typedef logic [REG_WIDTH-1:0]  reg_data_t;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t ZERO_REG = '0;

endpackage

// File: rtl/regfile_rdport.sv
// ---------------------------------------------------------------------------
// regfile_rdport
// One combinational read port of the register file.  Selects a stored
// register by address, forces register 0 and out-of-range addresses to
// zero, and (optionally) forwards same-cycle write data.
//
// Configuration macro: REGFILE_BYPASS_EN
//   defined   -> write-through forwarding of wd when we is high and wa
//                matches a valid, non-zero ra (suppressed during reset)
//   undefined -> rd reflects stored state only
//
// Ports:
//   reset  in   1              async reset (only used to gate the bypass)
//   regs   in   WIDTH x DEPTH  current register contents
//   ra     in   ADDR_W         read address
//   we     in   1              write enable of the write port
//   wa     in   ADDR_W         write address of the write port
//   wd     in   WIDTH          write data of the write port
//   rd     out  WIDTH          read data
// ---------------------------------------------------------------------------
module regfile_rdport
    import regfile_pkg::*;
#(
    parameter int WIDTH  = REG_WIDTH,
    parameter int DEPTH  = REG_DEPTH,
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic              reset,
    input  logic [WIDTH-1:0]  regs [DEPTH],
    input  logic [ADDR_W-1:0] ra,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [WIDTH-1:0]  wd,
    output logic [WIDTH-1:0]  rd
);

    logic [WIDTH-1:0] stored;
    logic             ra_valid;

    // The decode loop starts at 1 so register 0 never matches, and any
    // address >= DEPTH never matches either; both fall through to zero.
    // ra_valid records that the address names a real, writable register.
    always_comb begin
        stored   = '0;
        ra_valid = 1'b0;
        for (int i = 1; i < DEPTH; i++) begin
            if (ra == ADDR_W'(i)) begin
                stored   = regs[i];
                ra_valid = 1'b1;
            end
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic bypass_hit;

    // Forward only when the pending write would actually land in the
    // register being read; reusing ra_valid keeps reg 0 and out-of-range
    // addresses out of the bypass.
    assign bypass_hit = !reset && we && ra_valid && (wa == ra);
    assign rd         = bypass_hit ? wd : stored;
`else
    logic unused_bypass;

    assign unused_bypass = ^{reset, we, wa, wd, ra_valid};
    assign rd            = stored;
`endif

endmodule

// File: rtl/regfile_3p.sv
// ---------------------------------------------------------------------------
// regfile_3p
// Three-port general-purpose register file: two combinational read ports
// and one synchronous write port.  Register 0 reads as zero and ignores
// writes; addresses >= DEPTH read as zero and ignore writes.
//
// Configuration macro: REGFILE_BYPASS_EN (write-through forwarding on the
// read ports, see regfile_rdport).
//
// Ports:
//   clk    in   1       clock, state updates on rising edge
//   reset  in   1       asynchronous, active-high reset (clears all regs)
//   we3    in   1       write enable, port 3
//   ra1    in   ADDR_W  read address, port 1
//   ra2    in   ADDR_W  read address, port 2
//   wa3    in   ADDR_W  write address, port 3
//   wd3    in   WIDTH   write data, port 3
//   rd1    out  WIDTH   read data, port 1
//   rd2    out  WIDTH   read data, port 2
// ---------------------------------------------------------------------------
module regfile_3p
    import regfile_pkg::*;
#(
    parameter int WIDTH  = REG_WIDTH,
    parameter int DEPTH  = REG_DEPTH,
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we3,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    input  logic [ADDR_W-1:0] wa3,
    input  logic [WIDTH-1:0]  wd3,
    output logic [WIDTH-1:0]  rd1,
    output logic [WIDTH-1:0]  rd2
);

    logic [WIDTH-1:0] regs [DEPTH];
    logic             write_ok;

    assign write_ok = we3 && (wa3 != ADDR_W'(ZERO_REG));

    // Storage.  Entry 0 is cleared on reset and never written, so it is a
    // defined constant; the read ports mask it anyway.  Decoding by loop
    // means an address >= DEPTH simply matches no entry and is dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (write_ok) begin
            for (int i = 1; i < DEPTH; i++) begin
                if (wa3 == ADDR_W'(i)) begin
                    regs[i] <= wd3;
                end
            end
        end
    end

    regfile_rdport #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_rdport1 (
        .reset (reset),
        .regs  (regs),
        .ra    (ra1),
        .we    (we3),
        .wa    (wa3),
        .wd    (wd3),
        .rd    (rd1)
    );

    regfile_rdport #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_rdport2 (
        .reset (reset),
        .regs  (regs),
        .ra    (ra2),
        .we    (we3),
        .wa    (wa3),
        .wd    (wd3),
        .rd    (rd2)
    );

endmodule

// File: tb/tb_regfile_3p.sv
// ---------------------------------------------------------------------------
// tb_regfile_3p
// Self-checking bench for regfile_3p.  Two instances share all inputs: the
// default 32-entry file and a 20-entry file whose upper addresses are out
// of range.  An array model of the register contents predicts every read.
// ---------------------------------------------------------------------------
module tb_regfile_3p;

    localparam int SMALL_DEPTH = 20;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        we3 = 1'b0;
    logic [4:0]  ra1 = '0;
    logic [4:0]  ra2 = '0;
    logic [4:0]  wa3 = '0;
    logic [31:0] wd3 = '0;
    logic [31:0] rd1, rd2;
    logic [31:0] rd1_s, rd2_s;

    logic [31:0] model [32];
    bit          compare_en = 1'b0;
    int          checks = 0;
    int          errors = 0;

    regfile_3p dut (
        .clk   (clk),
        .reset (reset),
        .we3   (we3),
        .ra1   (ra1),
        .ra2   (ra2),
        .wa3   (wa3),
        .wd3   (wd3),
        .rd1   (rd1),
        .rd2   (rd2)
    );

    regfile_3p #(.DEPTH(SMALL_DEPTH)) dut_small (
        .clk   (clk),
        .reset (reset),
        .we3   (we3),
        .ra1   (ra1),
        .ra2   (ra2),
        .wa3   (wa3),
        .wd3   (wd3),
        .rd1   (rd1_s),
        .rd2   (rd2_s)
    );

    always #5 clk = ~clk;

    // Expected read value for a file of the given depth: zero for reg 0,
    // out-of-range addresses and during reset; forwarded write data when
    // the bypass is built in; otherwise whatever was last written.
    function automatic logic [31:0] exp_rd(input logic [4:0] ra, input int depth);
        if (reset || ra == 5'd0 || int'(ra) >= depth)
            return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (we3 && wa3 == ra)
            return wd3;
`endif
        return model[ra];
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
    endtask

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // Drive one cycle's worth of inputs shortly after a rising edge.
    task automatic apply_stimulus(input logic we, input logic [4:0] wa,
                                  input logic [31:0] wd, input logic [4:0] r1,
                                  input logic [4:0] r2, input logic rst);
        @(posedge clk);
        #2;
        reset = rst;
        if (rst) clear_model();
        we3 = we;
        wa3 = wa;
        wd3 = wd;
        ra1 = r1;
        ra2 = r2;
    endtask

    // Model write: a clock edge stores wd3 unless reset holds or the
    // target is register 0.  Inputs never change at the edge itself.
    always @(posedge clk) begin
        if (!reset && we3 && wa3 != 5'd0)
            model[wa3] = wd3;
    end

    // Continuous comparison of both instances against the model.
    always @(negedge clk) begin
        if (compare_en) begin
            check_output("rd1", rd1, exp_rd(ra1, 32));
            check_output("rd2", rd2, exp_rd(ra2, 32));
            check_output("rd1_small", rd1_s, exp_rd(ra1, SMALL_DEPTH));
            check_output("rd2_small", rd2_s, exp_rd(ra2, SMALL_DEPTH));
        end
    end

    initial begin
        clear_model();
        #1;
        reset = 1'b1;
        compare_en = 1'b1;

        // Reset held across edges; every address reads zero on both ports.
        for (int a = 0; a < 32; a++) begin
            ra1 = 5'(a);
            ra2 = 5'(31 - a);
            #1;
            check_output("reset_sweep_rd1", rd1, 32'h0);
            check_output("reset_sweep_rd2", rd2, 32'h0);
        end
        apply_stimulus(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0);

        // Basic write then read on both ports, then a disabled write.
        apply_stimulus(1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0, 1'b0);
        apply_stimulus(1'b0, 5'd5, 32'h12345678, 5'd5, 5'd5, 1'b0);
        #1;
        check_output("write_read_rd1", rd1, 32'hDEADBEEF);
        check_output("write_read_rd2", rd2, 32'hDEADBEEF);
        apply_stimulus(1'b0, 5'd0, 32'h0, 5'd5, 5'd0, 1'b0);
        #1;
        check_output("we_low_no_write", rd1, 32'hDEADBEEF);

        // Register 0 ignores writes.
        apply_stimulus(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 1'b0);
        apply_stimulus(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0);
        #1;
        check_output("reg0_rd1", rd1, 32'h0);

        // Same-cycle read/write hazard on register 7.
        apply_stimulus(1'b1, 5'd7, 32'h11, 5'd0, 5'd0, 1'b0);
        apply_stimulus(1'b1, 5'd7, 32'h22, 5'd7, 5'd0, 1'b0);
        #1;
`ifdef REGFILE_BYPASS_EN
        check_output("hazard_before_edge", rd1, 32'h22);
`else
        check_output("hazard_before_edge", rd1, 32'h11);
`endif
        apply_stimulus(1'b0, 5'd0, 32'h0, 5'd7, 5'd0, 1'b0);
        #1;
        check_output("hazard_after_edge", rd1, 32'h22);

        // Dual port concurrent reads.
        apply_stimulus(1'b1, 5'd3, 32'hA, 5'd0, 5'd0, 1'b0);
        apply_stimulus(1'b1, 5'd4, 32'hB, 5'd0, 5'd0, 1'b0);
        apply_stimulus(1'b0, 5'd0, 32'h0, 5'd3, 5'd4, 1'b0);
        #1;
        check_output("dual_rd1", rd1, 32'hA);
        check_output("dual_rd2", rd2, 32'hB);

        // Fill 1..31 with their index, then confirm values and the small
        // instance's out-of-range masking.
        for (int i = 1; i < 32; i++)
            apply_stimulus(1'b1, 5'(i), 32'(i), 5'd0, 5'd0, 1'b0);
        apply_stimulus(1'b0, 5'd0, 32'h0, 5'd9, 5'd25, 1'b0);
        #1;
        check_output("fill_rd1", rd1, 32'd9);
        check_output("fill_rd2", rd2, 32'd25);
        check_output("small_in_range", rd1_s, 32'd9);
        check_output("small_out_of_range", rd2_s, 32'h0);

        // Asynchronous reset between edges clears reads immediately.
        @(negedge clk);
        #2;
        reset = 1'b1;
        clear_model();
        #1;
        check_output("async_reset_rd1", rd1, 32'h0);
        check_output("async_reset_rd2", rd2, 32'h0);
        ra1 = 5'd31;
        #1;
        check_output("async_reset_rd1_31", rd1, 32'h0);
        apply_stimulus(1'b0, 5'd0, 32'h0, 5'd9, 5'd31, 1'b0);

        // Randomised traffic with biased address collisions and rare resets.
        for (int n = 0; n < 400; n++) begin
            logic [4:0] wa, r1, r2;
            wa = 5'($urandom);
            r1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom);
            r2 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom);
            apply_stimulus(1'($urandom), wa, $urandom, r1, r2,
                           $urandom_range(0, 39) == 0);
        end

        apply_stimulus(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0);
        @(posedge clk);
        compare_en = 1'b0;
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
